rr_trace_axi_writer: RTL and testbench
======================================

# rr_trace_axi_writer

Trace writeback stage directly downstream of the record trace merger. Drains the merger's output FIFO of 512-bit beats, each tagged with a valid-bit count, into a DRAM trace buffer over an AXI4 write master using incrementing bursts. Tracks outstanding bursts and committed byte count, and signals completion once every beat has been acknowledged after record finish.

## Interface
- AXI_WIDTH, 512, data beat width in bits; one beat is 64 B.
- AXI_ADDR_WIDTH, 64, AXI address width.
- OFFSET_WIDTH, 32, width of the beat-size and byte-counter fields.
- BURST_LEN, 16, maximum beats per burst; power of two; BURST_LEN*64 must divide 4096.
- MAX_OUTSTANDING, 4, maximum bursts awaiting a B response.
- FIFO_CNT_WIDTH, 10, width of the FIFO occupancy input.

Ports:
- clk  in  1  clock.
- sync_rst_n  in  1  reset; asynchronous, active-low.
- fifo_dout  in  AXI_WIDTH  first-word-fall-through beat data.
- fifo_dout_size  in  OFFSET_WIDTH  valid bits in the beat: a multiple of 8, 1..AXI_WIDTH, LSB-aligned.
- fifo_empty  in  1  FIFO empty.
- fifo_cnt  in  FIFO_CNT_WIDTH  FIFO occupancy in beats.
- fifo_rd_en  out  1  pops one beat.
- buf_base  in  AXI_ADDR_WIDTH  DRAM buffer base; 4 KiB-aligned; sampled at start.
- buf_size  in  OFFSET_WIDTH  buffer size in bytes; a multiple of BURST_LEN*64; sampled at start.
- start  in  1  one-cycle pulse that arms the writer.
- record_finish  in  1  one-cycle pulse: the upstream merger has flushed.
- bytes_committed  out  OFFSET_WIDTH  bytes acknowledged with OKAY.
- overflow  out  1  sticky flag: the buffer filled up.
- bresp_err  out  1  sticky flag: a non-OKAY B response was received.
- done  out  1  level: the drain is complete.
- m_awaddr  out  AXI_ADDR_WIDTH
- m_awlen  out  8
- m_awsize  out  3
- m_awburst  out  2
- m_awvalid  out  1
- m_awready  in  1
- m_wdata  out  AXI_WIDTH
- m_wstrb  out  AXI_WIDTH/8
- m_wlast  out  1
- m_wvalid  out  1
- m_wready  in  1
- m_bresp  in  2
- m_bvalid  in  1
- m_bready  out  1

## Operation
- **Reset:** all outputs 0, except:
  - m_awsize = 6 (constant);
  - m_awburst = INCR (constant);
  - m_bready = 1 (constant).
  - Internal state: state = IDLE, wr_off = 0, outstanding = 0, fin_seen = 0.
- **IDLE:** a start pulse latches buf_base and buf_size, clears all counters and flags, and moves to WAIT.
- **WAIT:**
  - Let n = min(fifo_cnt, BURST_LEN, (buf_size - wr_off)/64).
  - Issue a burst when outstanding < MAX_OUTSTANDING and either:
    - fifo_cnt ≥ BURST_LEN, or
    - fin_seen && fifo_cnt > 0 (flush, which may produce a short burst).
  - On issue: latch m_awaddr = buf_base + wr_off and m_awlen = n - 1, then go to ADDR.
- **ADDR:** hold m_awvalid until m_awready, then go to DATA.
  - AW-before-W ordering: no W beat is driven while in ADDR.
- **DATA:** the FIFO drives the W channel combinationally.
  - m_wvalid = ~fifo_empty.
  - m_wdata = fifo_dout.
  - m_wstrb = (1 << fifo_dout_size/8) - 1.
  - m_wlast asserts on beat n.
  - fifo_rd_en = m_wvalid && m_wready.
  - On the last handshake: wr_off += n*64, outstanding += 1, return to WAIT.
- **B channel:** each m_bvalid decrements outstanding.
  - OKAY adds that burst's byte count (sum of the wstrb popcounts, queued per burst in a MAX_OUTSTANDING-deep FIFO) to bytes_committed.
  - Any non-OKAY response sets bresp_err.
  - A B response and a burst completion in the same cycle leave outstanding unchanged.
- **record_finish:** sets fin_seen in any state.
- **Done condition:** WAIT && fin_seen && fifo_empty && outstanding == 0 → done = 1 and state DONE.
  - DONE holds until the next start, which re-arms the writer.
- **Full buffer:** when wr_off == buf_size, behaviour depends on configuration.
  - Without the wrap macro: overflow = 1; no more bursts are issued; the FIFO is not popped.
  - Done still asserts once fin_seen is set and outstanding == 0, regardless of FIFO contents.
- **Reset mid-burst:** abandons the AXI transaction; the slave is also reset under the same reset.

## Timing
- AW is issued no earlier than 1 cycle after the WAIT condition holds (the address is registered).
- First W beat: the cycle after the AW handshake.
- Throughput: 1 beat/cycle while in DATA.
  - Back-to-back bursts incur 2 idle cycles (WAIT→ADDR→DATA) when awready is already high.
- bytes_committed updates 1 cycle after the B handshake.
- done rises 1 cycle after the done condition.
- start while not IDLE/DONE: ignored.

## Configuration
- RR_TRACE_WRAP_EN defined:
  - When wr_off reaches buf_size it resets to 0 and the buffer is treated as a ring; overflow is never set.
  - bytes_committed keeps counting modulo 2^OFFSET_WIDTH.
- RR_TRACE_WRAP_EN undefined: stop-on-full behaviour as described under Operation.

## Test plan
- **Full bursts:** base 0x1000_0000, size 4096, 32 full beats preloaded, awready/wready constantly high.
  - Expect two bursts, at 0x1000_0000 and 0x1000_0400, each awlen 15.
  - Expect bytes_committed = 2048 after both B responses.
- **Flush:** 3 beats, last beat size 136 bits, then record_finish.
  - Expect one burst with awlen 2 and last wstrb = 0x1FFFF.
  - Expect bytes_committed = 145 and done = 1.
- **Overflow:** buf_size 1024 (without RR_TRACE_WRAP_EN), 40 beats offered.
  - Expect one burst; overflow = 1; 24 beats left in the FIFO; done asserts after record_finish.
- **Wrap:** same stimulus as the overflow case with RR_TRACE_WRAP_EN defined.
  - Expect the third burst addressed at buf_base.
  - Expect overflow = 0 and bytes_committed = 2560.
- **Backpressure:** random awready/wready, B responses delayed 50 cycles, MAX_OUTSTANDING = 4, 128 beats.
  - Expect outstanding never to exceed 4.
  - Expect every beat written exactly once, in order.
- **Error and reset:** a SLVERR on the 2nd B response sets bresp_err, and bytes_committed excludes that burst; an asynchronous reset mid-DATA clears all outputs immediately.

Source files
------------

// File: rtl/rr_trace_axi_writer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the trace writer and the DRAM slave.
interface rr_trace_axi_writer_if #(
   parameter int AXI_WIDTH      = 512,
   parameter int AXI_ADDR_WIDTH = 64
);
   logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
   logic [7:0]                m_awlen;
   logic [2:0]                m_awsize;
   logic [1:0]                m_awburst;
   logic                      m_awvalid;
   logic                      m_awready;
   logic [AXI_WIDTH-1:0]      m_wdata;
   logic [AXI_WIDTH/8-1:0]    m_wstrb;
   logic                      m_wlast;
   logic                      m_wvalid;
   logic                      m_wready;
   logic [1:0]                m_bresp;
   logic                      m_bvalid;
   logic                      m_bready;

   modport master (
      output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
      output m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
      input  m_awready, m_wready, m_bresp, m_bvalid
   );

   modport slave (
      input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
      input  m_wdata, m_wstrb, m_wlast, m_wvalid, m_bready,
      output m_awready, m_wready, m_bresp, m_bvalid
   );
endinterface

// File: rtl/rr_trace_axi_writer.sv
// Trace writeback: drains FWFT trace-FIFO beats into a DRAM buffer with AXI4 INCR bursts.
// Define RR_TRACE_WRAP_EN to treat the buffer as a ring instead of stopping when it fills.
module rr_trace_axi_writer #(
   parameter int AXI_WIDTH       = 512,
   parameter int AXI_ADDR_WIDTH  = 64,
   parameter int OFFSET_WIDTH    = 32,
   parameter int BURST_LEN       = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int FIFO_CNT_WIDTH  = 10
) (
   input  logic                      clk,
   input  logic                      sync_rst_n,
   input  logic [AXI_WIDTH-1:0]      fifo_dout,
   input  logic [OFFSET_WIDTH-1:0]   fifo_dout_size,
   input  logic                      fifo_empty,
   input  logic [FIFO_CNT_WIDTH-1:0] fifo_cnt,
   output logic                      fifo_rd_en,
   input  logic [AXI_ADDR_WIDTH-1:0] buf_base,
   input  logic [OFFSET_WIDTH-1:0]   buf_size,
   input  logic                      start,
   input  logic                      record_finish,
   output logic [OFFSET_WIDTH-1:0]   bytes_committed,
   output logic                      overflow,
   output logic                      bresp_err,
   output logic                      done,
   rr_trace_axi_writer_if.master     m
);
   localparam int STRB_W = AXI_WIDTH / 8;
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_DONE} state_t;
   state_t state, state_nxt;

   logic [AXI_ADDR_WIDTH-1:0] base_q, awaddr_q;
   logic [OFFSET_WIDTH-1:0]   size_q, wr_off, wr_next, burst_bytes, bytes_q;
   logic [OUT_W-1:0]          outstanding;
   logic [7:0]                awlen_q, beat_cnt;
   logic                      fin_seen, overflow_q, bresp_err_q, done_q;

   // Per-burst byte totals, retired in B-response order.
   logic [OFFSET_WIDTH-1:0]   bq_mem [MAX_OUTSTANDING];
   logic [PTR_W-1:0]          bq_wr, bq_rd;

   logic [OFFSET_WIDTH-1:0]   cnt_ext, room, n_beats, beat_bytes;
   logic                      buf_full, issue, drain_done, arm;
   logic                      in_data, wvalid, w_hs, last_hs, b_hs;
   logic [STRB_W-1:0]         wstrb;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   assign cnt_ext    = OFFSET_WIDTH'(fifo_cnt);
   assign room       = (size_q - wr_off) >> 6;
   assign beat_bytes = fifo_dout_size >> 3;
   assign wr_next    = wr_off + ((OFFSET_WIDTH'(awlen_q) + 1'b1) << 6);

`ifdef RR_TRACE_WRAP_EN
   assign buf_full = 1'b0;
`else
   assign buf_full = (wr_off == size_q);
`endif

   always_comb begin
      n_beats = cnt_ext;
      if (n_beats > OFFSET_WIDTH'(BURST_LEN)) n_beats = OFFSET_WIDTH'(BURST_LEN);
      if (n_beats > room)                     n_beats = room;
   end

   // A full (stopped) buffer lets the drain finish with beats still in the FIFO.
   assign drain_done = (state == S_WAIT) && fin_seen && (outstanding == '0) &&
                       (fifo_empty || buf_full);
   assign issue      = (state == S_WAIT) && !drain_done &&
                       (outstanding < OUT_W'(MAX_OUTSTANDING)) && (room != '0) &&
                       ((cnt_ext >= OFFSET_WIDTH'(BURST_LEN)) || (fin_seen && (cnt_ext != '0)));
   assign arm        = start && ((state == S_IDLE) || (state == S_DONE));

   assign in_data = (state == S_DATA);
   assign wvalid  = in_data && !fifo_empty;
   assign w_hs    = wvalid && m.m_wready;
   assign last_hs = w_hs && (beat_cnt == awlen_q);
   assign b_hs    = m.m_bvalid;

   always_comb begin
      wstrb = '0;
      for (int i = 0; i < STRB_W; i++) wstrb[i] = (OFFSET_WIDTH'(i) < beat_bytes);
   end

   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) state <= S_IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (arm)        state_nxt = S_WAIT;
         S_WAIT:         if (drain_done) state_nxt = S_DONE;
                         else if (issue) state_nxt = S_ADDR;
         S_ADDR:         if (m.m_awready) state_nxt = S_DATA;
         S_DATA:         if (last_hs)    state_nxt = S_WAIT;
         default:                        state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         base_q      <= '0;
         size_q      <= '0;
         awaddr_q    <= '0;
         awlen_q     <= '0;
         beat_cnt    <= '0;
         wr_off      <= '0;
         burst_bytes <= '0;
         bytes_q     <= '0;
         outstanding <= '0;
         fin_seen    <= 1'b0;
         overflow_q  <= 1'b0;
         bresp_err_q <= 1'b0;
         done_q      <= 1'b0;
         bq_wr       <= '0;
         bq_rd       <= '0;
      end else if (arm) begin
         base_q      <= buf_base;
         size_q      <= buf_size;
         wr_off      <= '0;
         bytes_q     <= '0;
         outstanding <= '0;
         fin_seen    <= record_finish;
         overflow_q  <= 1'b0;
         bresp_err_q <= 1'b0;
         done_q      <= 1'b0;
         bq_wr       <= '0;
         bq_rd       <= '0;
      end else begin
         if (record_finish) fin_seen <= 1'b1;
         if (issue) begin
            awaddr_q    <= base_q + AXI_ADDR_WIDTH'(wr_off);
            awlen_q     <= 8'(n_beats - 1'b1);
            beat_cnt    <= '0;
            burst_bytes <= '0;
         end
         if (w_hs) begin
            beat_cnt    <= beat_cnt + 8'd1;
            burst_bytes <= burst_bytes + beat_bytes;
         end
         if (last_hs) begin
`ifdef RR_TRACE_WRAP_EN
            wr_off <= (wr_next == size_q) ? '0 : wr_next;
`else
            wr_off <= wr_next;
`endif
            bq_wr <= ptr_inc(bq_wr);
         end
         case ({last_hs, b_hs})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: ;
         endcase
         if (b_hs) begin
            bq_rd <= ptr_inc(bq_rd);
            if (m.m_bresp == 2'b00) bytes_q     <= bytes_q + bq_mem[bq_rd];
            else                    bresp_err_q <= 1'b1;
         end
         if ((state == S_WAIT) && buf_full) overflow_q <= 1'b1;
         if (drain_done)                    done_q     <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (last_hs) bq_mem[bq_wr] <= burst_bytes + beat_bytes;
   end

   assign fifo_rd_en      = w_hs;
   assign bytes_committed = bytes_q;
   assign overflow        = overflow_q;
   assign bresp_err       = bresp_err_q;
   assign done            = done_q;

   assign m.m_awaddr  = awaddr_q;
   assign m.m_awlen   = awlen_q;
   assign m.m_awsize  = 3'd6;
   assign m.m_awburst = 2'b01;
   assign m.m_awvalid = (state == S_ADDR);
   assign m.m_wdata   = in_data ? fifo_dout : '0;
   assign m.m_wstrb   = in_data ? wstrb : '0;
   assign m.m_wlast   = in_data && (beat_cnt == awlen_q);
   assign m.m_wvalid  = wvalid;
   assign m.m_bready  = 1'b1;
endmodule

// File: tb/tb_rr_trace_axi_writer.sv
// Directed bench for rr_trace_axi_writer: FWFT FIFO model, AXI slave model, linear checks.
module tb_rr_trace_axi_writer;
   logic         clk = 1'b0;
   logic         sync_rst_n;
   logic [511:0] fifo_dout;
   logic [31:0]  fifo_dout_size;
   logic         fifo_empty;
   logic [9:0]   fifo_cnt;
   logic         fifo_rd_en;
   logic [63:0]  buf_base;
   logic [31:0]  buf_size;
   logic         start, record_finish;
   logic [31:0]  bytes_committed;
   logic         overflow, bresp_err, done;

   int checks = 0;
   int errors = 0;

   rr_trace_axi_writer_if #(.AXI_WIDTH(512), .AXI_ADDR_WIDTH(64)) axi ();

   rr_trace_axi_writer dut (
      .clk(clk), .sync_rst_n(sync_rst_n),
      .fifo_dout(fifo_dout), .fifo_dout_size(fifo_dout_size),
      .fifo_empty(fifo_empty), .fifo_cnt(fifo_cnt), .fifo_rd_en(fifo_rd_en),
      .buf_base(buf_base), .buf_size(buf_size),
      .start(start), .record_finish(record_finish),
      .bytes_committed(bytes_committed), .overflow(overflow),
      .bresp_err(bresp_err), .done(done), .m(axi)
   );

   always #5 clk = ~clk;

   // FWFT FIFO model
   logic [511:0] mem_data [0:1023];
   logic [31:0]  mem_size [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   logic fifo_flush = 1'b0;

   assign fifo_empty     = (wr_ptr == rd_ptr);
   assign fifo_cnt       = 10'(wr_ptr - rd_ptr);
   assign fifo_dout      = mem_data[rd_ptr[9:0]];
   assign fifo_dout_size = mem_size[rd_ptr[9:0]];

   always @(posedge clk) begin
      if (fifo_flush)      rd_ptr <= wr_ptr;
      else if (fifo_rd_en) rd_ptr <= rd_ptr + 1;
   end

   function automatic logic [63:0] pat(input int i);
      return 64'hD00D_0000_0000_0000 | 64'(i);
   endfunction

   // AXI slave model
   typedef struct { int due; logic [1:0] resp; } bent_t;
   bent_t bq[$];
   int cyc = 0, aw_cnt = 0, w_cnt = 0, wl_cnt = 0, b_cnt = 0, max_out = 0;
   int bdelay = 5;
   int err_idx = -1;
   bit rnd_en = 1'b0;
   bit hold_w = 1'b0;
   logic [63:0] aw_addr_log [0:63];
   logic [7:0]  aw_len_log  [0:63];
   logic [63:0] w_log       [0:511];
   logic [63:0] last_wstrb = '0;

   always @(posedge clk or negedge sync_rst_n) begin
      if (!sync_rst_n) begin
         bq.delete();
         axi.m_bvalid  <= 1'b0;
         axi.m_bresp   <= 2'b00;
         axi.m_awready <= 1'b0;
         axi.m_wready  <= 1'b0;
      end else begin
         cyc <= cyc + 1;
         if (axi.m_awvalid && axi.m_awready) begin
            aw_addr_log[aw_cnt] <= axi.m_awaddr;
            aw_len_log[aw_cnt]  <= axi.m_awlen;
            aw_cnt <= aw_cnt + 1;
         end
         if (bq.size() > 0 && bq[0].due <= cyc) begin
            axi.m_bvalid <= 1'b1;
            axi.m_bresp  <= bq[0].resp;
            void'(bq.pop_front());
            b_cnt <= b_cnt + 1;
         end else begin
            axi.m_bvalid <= 1'b0;
            axi.m_bresp  <= 2'b00;
         end
         if (axi.m_wvalid && axi.m_wready) begin
            w_log[w_cnt] <= axi.m_wdata[63:0];
            w_cnt <= w_cnt + 1;
            if (axi.m_wlast) begin
               last_wstrb <= axi.m_wstrb;
               bq.push_back('{cyc + bdelay, (wl_cnt == err_idx) ? 2'b10 : 2'b00});
               wl_cnt <= wl_cnt + 1;
            end
         end
         axi.m_awready <= rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
         axi.m_wready  <= hold_w ? 1'b0 : (rnd_en ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   always @(negedge clk) begin
      if (aw_cnt - b_cnt > max_out) max_out <= aw_cnt - b_cnt;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_beat(input int sz);
      mem_data[wr_ptr[9:0]] = {8{pat(wr_ptr)}};
      mem_size[wr_ptr[9:0]] = sz;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic arm(input logic [63:0] base, input logic [31:0] size);
      buf_base = base;
      buf_size = size;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic finish_pulse();
      record_finish = 1'b1;
      @(negedge clk);
      record_finish = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && done !== 1'b1; i++) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int aw0, b0, w0, p0, errs_w;
      for (int i = 0; i < 1024; i++) begin
         mem_data[i] = '0;
         mem_size[i] = '0;
      end
      sync_rst_n = 1'b0; start = 1'b0; record_finish = 1'b0;
      buf_base = '0; buf_size = '0;
      #3;
      check("rst_awsize",  64'(axi.m_awsize), 64'd6);
      check("rst_awburst", 64'(axi.m_awburst), 64'd1);
      check("rst_bready",  64'(axi.m_bready), 64'd1);
      check("rst_awvalid", 64'(axi.m_awvalid), 64'd0);
      check("rst_wvalid",  64'(axi.m_wvalid), 64'd0);
      check("rst_outs",    {bytes_committed, 28'd0, overflow, bresp_err, done, fifo_rd_en}, 64'd0);
      repeat (3) @(negedge clk);
      sync_rst_n = 1'b1;
      @(negedge clk);

      // Full bursts
      aw0 = aw_cnt; b0 = b_cnt; w0 = w_cnt; p0 = wr_ptr;
      for (int i = 0; i < 32; i++) push_beat(512);
      arm(64'h1000_0000, 32'd4096);
      for (int i = 0; i < 500 && b_cnt < b0 + 2; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("t1_aw_cnt",  64'(aw_cnt - aw0), 64'd2);
      check("t1_addr0",   aw_addr_log[aw0], 64'h1000_0000);
      check("t1_addr1",   aw_addr_log[aw0 + 1], 64'h1000_0400);
      check("t1_len0",    64'(aw_len_log[aw0]), 64'd15);
      check("t1_len1",    64'(aw_len_log[aw0 + 1]), 64'd15);
      check("t1_w_cnt",   64'(w_cnt - w0), 64'd32);
      errs_w = 0;
      for (int k = 0; k < 32; k++) if (w_log[w0 + k] !== pat(p0 + k)) errs_w++;
      check("t1_w_order", 64'(errs_w), 64'd0);
      check("t1_bytes",   64'(bytes_committed), 64'd2048);
      check("t1_no_done", 64'(done), 64'd0);
      finish_pulse();
      wait_done(100);
      check("t1_done",    64'(done), 64'd1);

      // Flush with a short last beat
      aw0 = aw_cnt;
      push_beat(512); push_beat(512); push_beat(136);
      arm(64'h2000_0000, 32'd4096);
      check("t2_done_clr", 64'(done), 64'd0);
      repeat (3) @(negedge clk);
      check("t2_hold_aw",  64'(aw_cnt - aw0), 64'd0);
      finish_pulse();
      wait_done(200);
      check("t2_aw_cnt",  64'(aw_cnt - aw0), 64'd1);
      check("t2_addr",    aw_addr_log[aw0], 64'h2000_0000);
      check("t2_len",     64'(aw_len_log[aw0]), 64'd2);
      check("t2_wstrb",   last_wstrb, 64'h1FFFF);
      check("t2_bytes",   64'(bytes_committed), 64'd145);
      check("t2_done",    64'(done), 64'd1);

      // Overflow: buffer holds one burst
      aw0 = aw_cnt; b0 = b_cnt;
      for (int i = 0; i < 40; i++) push_beat(512);
      arm(64'h3000_0000, 32'd1024);
      for (int i = 0; i < 500 && b_cnt < b0 + 1; i++) @(negedge clk);
      repeat (5) @(negedge clk);
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_left",     64'(fifo_cnt), 64'd24);
      check("t3_aw_cnt",   64'(aw_cnt - aw0), 64'd1);
      check("t3_bytes",    64'(bytes_committed), 64'd1024);
      check("t3_no_done",  64'(done), 64'd0);
      finish_pulse();
      wait_done(100);
      check("t3_done",     64'(done), 64'd1);
      check("t3_left_end", 64'(fifo_cnt), 64'd24);
      check("t3_aw_end",   64'(aw_cnt - aw0), 64'd1);
      fifo_flush = 1'b1;
      @(negedge clk);
      fifo_flush = 1'b0;

      // Backpressure: random ready, slow B
      aw0 = aw_cnt; b0 = b_cnt; w0 = w_cnt; p0 = wr_ptr;
      rnd_en = 1'b1; bdelay = 50;
      for (int i = 0; i < 128; i++) push_beat(512);
      arm(64'h5000_0000, 32'd8192);
      for (int i = 0; i < 5000 && b_cnt < b0 + 8; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("t4_aw_cnt",  64'(aw_cnt - aw0), 64'd8);
      check("t4_addr7",   aw_addr_log[aw0 + 7], 64'h5000_1C00);
      check("t4_w_cnt",   64'(w_cnt - w0), 64'd128);
      errs_w = 0;
      for (int k = 0; k < 128; k++) if (w_log[w0 + k] !== pat(p0 + k)) errs_w++;
      check("t4_w_order", 64'(errs_w), 64'd0);
      check("t4_max_out_le4", 64'(max_out <= 4), 64'd1);
      check("t4_bytes",   64'(bytes_committed), 64'd8192);
      rnd_en = 1'b0; bdelay = 5;
      finish_pulse();
      wait_done(200);
      check("t4_done",    64'(done), 64'd1);

      // SLVERR on the second B response
      aw0 = aw_cnt; b0 = b_cnt;
      err_idx = wl_cnt + 1;
      for (int i = 0; i < 48; i++) push_beat(512);
      arm(64'h4000_0000, 32'd4096);
      for (int i = 0; i < 1000 && b_cnt < b0 + 3; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("t5_aw_cnt", 64'(aw_cnt - aw0), 64'd3);
      check("t5_berr",   64'(bresp_err), 64'd1);
      check("t5_bytes",  64'(bytes_committed), 64'd2048);
      err_idx = -1;
      finish_pulse();
      wait_done(100);
      check("t5_done",   64'(done), 64'd1);

      // Asynchronous reset while a burst is in DATA
      hold_w = 1'b1;
      for (int i = 0; i < 16; i++) push_beat(512);
      arm(64'h6000_0000, 32'd4096);
      for (int i = 0; i < 50 && axi.m_wvalid !== 1'b1; i++) @(negedge clk);
      check("t6_in_data", 64'(axi.m_wvalid), 64'd1);
      #2;
      sync_rst_n = 1'b0;
      #1;
      check("t6_wvalid",  64'(axi.m_wvalid), 64'd0);
      check("t6_awaddr",  axi.m_awaddr, 64'd0);
      check("t6_wstrb",   axi.m_wstrb, 64'd0);
      check("t6_outs",    {bytes_committed, 28'd0, overflow, bresp_err, done, fifo_rd_en}, 64'd0);
      @(negedge clk);
      hold_w = 1'b0;
      sync_rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_idle_aw", 64'(axi.m_awvalid), 64'd0);
      check("t6_no_pop",  64'(fifo_cnt), 64'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
